// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release/long-press pulses.
// Define PRESS_COUNT_EN to enable the 8-bit wrapping press counter; otherwise press_count is 0.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic          REL_LEVEL = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LCNT_MAX  = CW'(LONG_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          s;
    logic [CW-1:0] lcnt_inc;
    logic          long_hit;

    assign s        = sync2_q ^ REL_LEVEL;
    assign lcnt_inc = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + ONE;
    assign long_hit = (lcnt_q == LONG_LAST) && !long_done_q;

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    lcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + ONE;
                end
            end
            HELD: begin
                lcnt_d = lcnt_inc;
                if (long_hit) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = ONE;
                end
            end
            RELEASE_WAIT: begin
                // The hold timer keeps running through release bounce.
                lcnt_d = lcnt_inc;
                if (long_hit) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (s) begin
                    state_d = HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    level_d     = 1'b0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= REL_LEVEL;
            sync2_q     <= REL_LEVEL;
            state_q     <= IDLE;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

`ifdef PRESS_COUNT_EN
    logic [7:0] count_q, count_d;

    // Count advances on the same edge that raises press_pulse.
    always_comb begin
        count_d = count_q;
        if (press_d) count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= 8'h00;
        else        count_q <= count_d;
    end

    assign press_count = count_q;
`else
    assign press_count = 8'h00;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1).
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;
    localparam int K_PRESS = 0, K_LONG = 1, K_REL = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic       lvl;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'h00;
    ev_t        exp_q[$];

    button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .press_count(press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_cnt();
`ifdef PRESS_COUNT_EN
        return exp_cnt;
`else
        return 8'h00;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Input changed just after edge e becomes a pulse registered at edge e+D+2.
    task automatic push_ev(input int kind, input int at);
        ev_t e;
        if (kind == K_PRESS) exp_cnt = exp_cnt + 8'd1;
        e.kind = kind;
        e.cyc  = at;
        e.lvl  = (kind != K_REL);
        e.cnt  = model_cnt();
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse kind=%0d cyc=%0d (no event expected)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || btn_level != e.lvl || press_count != e.cnt) begin
                errors++;
                $display("FAIL pulse got kind=%0d cyc=%0d lvl=%0b cnt=%0d, expected kind=%0d cyc=%0d lvl=%0b cnt=%0d",
                         kind, cyc, btn_level, press_count, e.kind, e.cyc, e.lvl, e.cnt);
            end else begin
                $display("ok   pulse kind=%0d cyc=%0d lvl=%0b cnt=%0d", kind, cyc, btn_level, press_count);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse kind=%0d expected at cyc=%0d, still absent at cyc=%0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (press_pulse)   check_event(K_PRESS);
            if (long_pulse)    check_event(K_LONG);
            if (release_pulse) check_event(K_REL);
        end
    end

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b0;   // pressed while in reset
        wait_cyc(1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} != 12'h000) begin
                errors++;
                $display("FAIL reset_outputs got lvl=%0b p=%0b r=%0b l=%0b cnt=%0d, expected all 0",
                         btn_level, press_pulse, release_pulse, long_pulse, press_count);
            end else $display("ok   reset_outputs all zero");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_ev(K_PRESS, cyc + D + 2);
        wait_cyc(10);
        btn_in = 1'b1;
        push_ev(K_REL, cyc + D + 2);
        wait_cyc(12);

        // Long hold: long 20 cycles after press, release 6 after letting go.
        btn_in = 1'b0;
        push_ev(K_PRESS, cyc + D + 2);
        push_ev(K_LONG, cyc + D + 2 + L);
        wait_cyc(30);
        btn_in = 1'b1;
        push_ev(K_REL, cyc + D + 2);
        wait_cyc(12);

        // Bounce: 0 x3, 1 x1, then 0 held.
        btn_in = 1'b0;
        wait_cyc(3);
        btn_in = 1'b1;
        wait_cyc(1);
        btn_in = 1'b0;
        push_ev(K_PRESS, cyc + D + 2);
        wait_cyc(10);
        btn_in = 1'b1;
        push_ev(K_REL, cyc + D + 2);
        wait_cyc(12);

        // 2-cycle release glitch while held.
        btn_in = 1'b0;
        push_ev(K_PRESS, cyc + D + 2);
        push_ev(K_LONG, cyc + D + 2 + L);
        wait_cyc(8);
        btn_in = 1'b1;
        wait_cyc(2);
        btn_in = 1'b0;
        wait_cyc(4);
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL glitch_level got %0b, expected 1", btn_level);
        end else $display("ok   glitch_level stays 1");
        @(posedge clk); #1;
        wait_cyc(20);
        btn_in = 1'b1;
        push_ev(K_REL, cyc + D + 2);
        wait_cyc(12);

        // Press of D-1 cycles is rejected; press of exactly D cycles is accepted.
        btn_in = 1'b0;
        wait_cyc(D - 1);
        btn_in = 1'b1;
        wait_cyc(10);
        btn_in = 1'b0;
        push_ev(K_PRESS, cyc + D + 2);
        wait_cyc(D);
        btn_in = 1'b1;
        push_ev(K_REL, cyc + D + 2);
        wait_cyc(12);

        // Reset in the middle of debouncing a press: no pulses.
        btn_in = 1'b0;
        wait_cyc(4);
        rst_n  = 1'b0;
        btn_in = 1'b1;
        wait_cyc(2);
        rst_n   = 1'b1;
        exp_cnt = 8'h00;
        wait_cyc(10);

        // 257 clean presses: counter wraps to 1 when enabled.
        for (int i = 0; i < 257; i++) begin
            btn_in = 1'b0;
            push_ev(K_PRESS, cyc + D + 2);
            wait_cyc(8);
            btn_in = 1'b1;
            push_ev(K_REL, cyc + D + 2);
            wait_cyc(8);
        end
        wait_cyc(10);
        @(negedge clk);
        checks++;
`ifdef PRESS_COUNT_EN
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL press_count_final got %0d, expected 1", press_count);
        end else $display("ok   press_count_final %0d", press_count);
`else
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL press_count_final got %0d, expected 0", press_count);
        end else $display("ok   press_count_final %0d", press_count);
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding, expected 0", exp_q.size());
        end else $display("ok   no outstanding events");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
